uart_tx_ctrl: RTL and testbench

Transmit-side frame controller for the UART TX path. Accepts a parallel word, sequences start bit, LSB-first data bits, optional parity bit and stop bit onto the serial line. Issues the one-cycle load strobe that makes the parity calculator capture only accepted words, and inserts that calculator's `par_bit` into the frame. Sits between the register-file/FIFO side (`P_DATA`/`Data_Valid`) and the `TX_OUT` pad.

---
 rtl/uart_tx_ctrl.sv | 111 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, LSB-first data, optional parity, stop bit.
// Accepts a new word in IDLE or STOP so back-to-back frames run with no idle gap.
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  par_bit,
   output logic                  par_load,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    par_en_q, par_en_d;
   logic                    tx_q, tx_d;
   logic                    busy_q, busy_d;
   logic                    par_load_q, par_load_d;
   logic                    accept;

   always_comb begin
      accept     = Data_Valid && ((state_q == IDLE) || (state_q == STOP));
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      par_en_d   = par_en_q;
      par_load_d = accept;

      unique case (state_q)
         IDLE, STOP: begin
            if (accept) begin
               state_d  = START;
               shift_d  = P_DATA;
               cnt_d    = '0;
               par_en_d = PAR_EN;
            end else begin
               state_d  = IDLE;
            end
         end
         START:  state_d = DATA;
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               state_d = par_en_q ? PARITY : STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARITY: state_d = STOP;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so the line changes on the edge that enters it.
      tx_d   = 1'b1;
      busy_d = 1'b1;
      unique case (state_d)
         IDLE:   busy_d = 1'b0;
         START:  tx_d   = 1'b0;
         DATA: begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
         end
         PARITY: tx_d   = par_bit;
         STOP:   tx_d   = 1'b1;
         default: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         par_en_q   <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         par_load_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         par_en_q   <= par_en_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         par_load_q <= par_load_d;
      end
   end

   assign TX_OUT   = tx_q;
   assign busy     = busy_q;
   assign par_load = par_load_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed frames plus randomized frames against a frame-level model,
// with a small parity-calculator stand-in that captures the word on par_load.
module tb_uart_tx_ctrl;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] P_DATA;
   logic          Data_Valid;
   logic          PAR_EN;
   logic          par_bit;
   logic          par_load;
   logic          TX_OUT;
   logic          busy;

   logic          par_typ;
   logic [DW-1:0] calc_word;

   int checks = 0;
   int errors = 0;
   logic [0:0] exp_q[$];

   always #5 clk = ~clk;

   uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .par_bit    (par_bit),
      .par_load   (par_load),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   // Parity calculator: registers the word on par_load, parity type applied combinationally.
   always @(posedge clk or negedge rst) begin
      if (!rst) calc_word <= '0;
      else if (par_load) calc_word <= P_DATA;
   end
   assign par_bit = (^calc_word) ^ par_typ;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line contents of one whole frame, built straight from the frame format.
   function automatic void push_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp);
      exp_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
      if (pen) exp_q.push_back((^d) ^ ptyp);
      exp_q.push_back(1'b1);
   endfunction

   task automatic chk_line(input string tag, input logic exp_pl);
      logic e;
      e = (exp_q.size() == 0) ? 1'bx : exp_q.pop_front();
      chk({tag, "_tx"}, TX_OUT, e);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_par_load"}, par_load, exp_pl);
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_tx"}, TX_OUT, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_par_load"}, par_load, 1'b0);
   endtask

   task automatic request(input logic [DW-1:0] d, input logic pen, input logic ptyp);
      P_DATA     = d;
      PAR_EN     = pen;
      par_typ    = ptyp;
      Data_Valid = 1'b1;
      push_frame(d, pen, ptyp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      logic [DW-1:0] d;
      logic          pen;
      logic          ptyp;
      int            len;
      int            inj;

      rst        = 1'b0;
      Data_Valid = 1'b0;
      P_DATA     = '0;
      PAR_EN     = 1'b0;
      par_typ    = 1'b0;

      tick();
      idle_chk("reset");
      rst = 1'b1;
      repeat (3) begin
         tick();
         idle_chk("post_reset");
      end

      // Even parity, 0xA5: 0,1,0,1,0,0,1,0,1,0,1
      request(8'hA5, 1'b1, 1'b0);
      tick();
      Data_Valid = 1'b0;
      for (int k = 0; k < 11; k++) begin
         chk_line($sformatf("even_a5_%0d", k), k == 0);
         tick();
      end
      idle_chk("even_idle");

      // No parity, 0x80
      request(8'h80, 1'b0, 1'b0);
      tick();
      Data_Valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk_line($sformatf("nopar_80_%0d", k), k == 0);
         tick();
      end
      idle_chk("nopar_idle");

      // Odd parity 0x01 with an ignored 0xFF request during DATA
      request(8'h01, 1'b1, 1'b1);
      tick();
      Data_Valid = 1'b0;
      for (int k = 0; k < 11; k++) begin
         chk_line($sformatf("odd_01_%0d", k), k == 0);
         if (k == 3) begin
            Data_Valid = 1'b1;
            P_DATA     = 8'hFF;
         end
         if (k == 4) Data_Valid = 1'b0;
         tick();
      end
      idle_chk("odd_idle");

      // Back-to-back 0x55 then 0x0F with Data_Valid held high
      request(8'h55, 1'b1, 1'b0);
      push_frame(8'h0F, 1'b1, 1'b0);
      tick();
      for (int k = 0; k < 22; k++) begin
         chk_line($sformatf("b2b_%0d", k), (k == 0) || (k == 11));
         if (k == 1) P_DATA = 8'h0F;
         if (k == 11) Data_Valid = 1'b0;
         tick();
      end
      idle_chk("b2b_idle");

      // Request exactly in STOP starts the next frame immediately
      d = DW'($urandom);
      request(d, 1'b1, 1'b0);
      tick();
      Data_Valid = 1'b0;
      for (int k = 0; k < 11; k++) begin
         chk_line($sformatf("tail_a_%0d", k), k == 0);
         if (k == 10) request(~d, 1'b0, 1'b0);
         tick();
      end
      for (int k = 0; k < 10; k++) begin
         chk_line($sformatf("tail_b_%0d", k), k == 0);
         if (k == 0) Data_Valid = 1'b0;
         tick();
      end
      idle_chk("tail_idle");

      // Request only during PARITY is dropped
      d = DW'($urandom);
      request(d, 1'b1, 1'b1);
      tick();
      Data_Valid = 1'b0;
      for (int k = 0; k < 11; k++) begin
         chk_line($sformatf("parreq_%0d", k), k == 0);
         if (k == 9) begin
            Data_Valid = 1'b1;
            P_DATA     = ~d;
         end
         if (k == 10) Data_Valid = 1'b0;
         tick();
      end
      idle_chk("parreq_idle");

      // Randomized frames with gaps and ignored mid-frame requests
      for (int f = 0; f < 20; f++) begin
         repeat ($urandom_range(0, 2)) begin
            idle_chk("rnd_gap");
            tick();
         end
         d    = DW'($urandom);
         pen  = 1'($urandom_range(0, 1));
         ptyp = 1'($urandom_range(0, 1));
         len  = 10 + int'(pen);
         inj  = $urandom_range(0, len - 2);
         request(d, pen, ptyp);
         tick();
         Data_Valid = 1'b0;
         for (int k = 0; k < len; k++) begin
            chk_line($sformatf("rnd%0d_%0d", f, k), k == 0);
            if (k == 1) P_DATA = DW'($urandom);
            if (k == inj) Data_Valid = 1'b1;
            if (k == inj + 1) Data_Valid = 1'b0;
            tick();
         end
         idle_chk($sformatf("rnd%0d_idle", f));
      end

      // Asynchronous reset in the middle of DATA
      request(DW'($urandom), 1'b1, 1'b0);
      tick();
      Data_Valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk_line($sformatf("arst_pre_%0d", k), k == 0);
         tick();
      end
      #2 rst = 1'b0;
      #1 idle_chk("arst_async");
      exp_q.delete();
      tick();
      idle_chk("arst_held");
      rst = 1'b1;
      repeat (3) begin
         tick();
         idle_chk("arst_release");
      end

      // First frame after reset
      request(8'h3C, 1'b0, 1'b0);
      tick();
      Data_Valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk_line($sformatf("after_rst_%0d", k), k == 0);
         tick();
      end
      idle_chk("after_rst_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
